// File: rtl/axi2per_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi2per_pkg
//  Description : Shared types and constants for the AXI-to-peripheral bridge
//                response stage: FSM state encoding, data-lane select bit
//                and AXI response codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi2per_pkg;

    // Response-stage FSM states
    typedef enum logic [1:0] {
        Idle    = 2'd0,
        WaitPer = 2'd1,
        Resp    = 2'd2
    } state_e;

    // Address bit that selects the upper 32-bit lane of the 64-bit R bus
    localparam int unsigned c_lane_sel_bit = 2;

    // AXI response codes
    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

endpackage
`default_nettype wire

// File: rtl/axi2per_rsp_channel.sv
`default_nettype none
// ============================================================================
//  Module      : axi2per_rsp_channel
//  Description : Response stage of the AXI-to-peripheral bridge. Tracks the
//                single outstanding peripheral transaction, captures the
//                peripheral response and returns it on AXI R and/or B, then
//                signals retirement back to the request stage.
//  Config      : AXI2PER_RSP_ERR_EN - when defined, a peripheral error flag
//                maps to SLVERR; otherwise every response is OKAY.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi2per_rsp_channel
    import axi2per_pkg::*;
#(
    parameter int unsigned PER_ID_WIDTH   = 5,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_USER_WIDTH = 6,
    parameter int unsigned AXI_ID_WIDTH   = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      trans_req_i,
    input  logic                      trans_we_i,
    input  logic                      trans_atop_r_i,
    input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i,
    output logic                      trans_r_valid_o,

    input  logic                      per_slave_r_valid_i,
    input  logic                      per_slave_r_opc_i,
    input  logic [PER_ID_WIDTH-1:0]   per_slave_r_id_i,
    input  logic [31:0]               per_slave_r_rdata_i,

    output logic                      axi_slave_r_valid_o,
    input  logic                      axi_slave_r_ready_i,
    output logic [AXI_DATA_WIDTH-1:0] axi_slave_r_data_o,
    output logic [1:0]                axi_slave_r_resp_o,
    output logic                      axi_slave_r_last_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_slave_r_id_o,
    output logic [AXI_USER_WIDTH-1:0] axi_slave_r_user_o,

    output logic                      axi_slave_b_valid_o,
    input  logic                      axi_slave_b_ready_i,
    output logic [1:0]                axi_slave_b_resp_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_slave_b_id_o,
    output logic [AXI_USER_WIDTH-1:0] axi_slave_b_user_o
);

    state_e                    r_state;
    state_e                    w_state_nxt;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic                      r_we;
    logic                      r_atop_r;
    logic                      r_lane_hi;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    logic [1:0]                r_resp;
    logic                      r_need_r;
    logic                      r_need_b;

    logic                      w_capture_req;
    logic                      w_capture_rsp;
    logic                      w_r_hs;
    logic                      w_b_hs;
    logic                      w_done;
    logic [1:0]                w_resp_code;
    logic                      w_unused;

`ifdef AXI2PER_RSP_ERR_EN
    assign w_resp_code = per_slave_r_opc_i ? c_resp_slverr : c_resp_okay;
    assign w_unused    = ^{trans_add_i, per_slave_r_id_i};
`else
    assign w_resp_code = c_resp_okay;
    assign w_unused    = ^{trans_add_i, per_slave_r_id_i, per_slave_r_opc_i};
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= Idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic, capture strobes and retirement detection
    always_comb begin
        w_state_nxt   = r_state;
        w_capture_req = 1'b0;
        w_capture_rsp = 1'b0;
        w_done        = 1'b0;
        w_r_hs        = r_need_r & axi_slave_r_ready_i;
        w_b_hs        = r_need_b & axi_slave_b_ready_i;
        case (r_state)
            Idle: begin
                if (trans_req_i) begin
                    w_capture_req = 1'b1;
                    w_state_nxt   = WaitPer;
                end
            end
            WaitPer: begin
                if (per_slave_r_valid_i) begin
                    w_capture_rsp = 1'b1;
                    w_state_nxt   = Resp;
                end
            end
            Resp: begin
                // Retire once nothing remains outstanding after this cycle's handshakes
                if ((~r_need_r | w_r_hs) & (~r_need_b | w_b_hs)) begin
                    w_done      = 1'b1;
                    w_state_nxt = Idle;
                end
            end
            default: begin
                w_state_nxt = Idle;
            end
        endcase
    end

    // Transaction attributes, response payload and per-channel pending flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_id      <= '0;
            r_we      <= 1'b0;
            r_atop_r  <= 1'b0;
            r_lane_hi <= 1'b0;
            r_rdata   <= '0;
            r_resp    <= '0;
            r_need_r  <= 1'b0;
            r_need_b  <= 1'b0;
        end else begin
            if (w_capture_req) begin
                r_id      <= trans_id_i;
                r_we      <= trans_we_i;
                r_atop_r  <= trans_atop_r_i;
                r_lane_hi <= trans_add_i[c_lane_sel_bit];
            end
            if (w_capture_rsp) begin
                r_rdata  <= r_lane_hi ? {per_slave_r_rdata_i, 32'h0}
                                      : {32'h0, per_slave_r_rdata_i};
                r_resp   <= w_resp_code;
                // trans_we_i is active low: 1 means read
                r_need_r <= r_we | r_atop_r;
                r_need_b <= ~r_we;
            end else begin
                r_need_r <= r_need_r & ~w_r_hs;
                r_need_b <= r_need_b & ~w_b_hs;
            end
        end
    end

    assign trans_r_valid_o     = w_done;

    assign axi_slave_r_valid_o = r_need_r;
    assign axi_slave_r_data_o  = r_rdata;
    assign axi_slave_r_resp_o  = r_resp;
    assign axi_slave_r_last_o  = 1'b1;
    assign axi_slave_r_id_o    = r_id;
    assign axi_slave_r_user_o  = '0;

    assign axi_slave_b_valid_o = r_need_b;
    assign axi_slave_b_resp_o  = r_resp;
    assign axi_slave_b_id_o    = r_id;
    assign axi_slave_b_user_o  = '0;

`ifndef SYNTHESIS
    a_no_per_rsp_in_idle : assert property (@(posedge clk_i) disable iff (rst_i)
        !((r_state == Idle) && per_slave_r_valid_i));
    a_no_req_when_busy : assert property (@(posedge clk_i) disable iff (rst_i)
        !((r_state != Idle) && trans_req_i));
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi2per_rsp_channel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_axi2per_rsp_channel
//  Description : Scoreboard testbench for axi2per_rsp_channel. Driver issues
//                transactions and pushes expected responses; a monitor pops
//                and compares on every R/B handshake and retirement pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi2per_rsp_channel;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        trans_req_i = 1'b0;
    logic        trans_we_i = 1'b0;
    logic        trans_atop_r_i = 1'b0;
    logic [2:0]  trans_id_i = '0;
    logic [31:0] trans_add_i = '0;
    logic        trans_r_valid_o;
    logic        per_slave_r_valid_i = 1'b0;
    logic        per_slave_r_opc_i = 1'b0;
    logic [4:0]  per_slave_r_id_i = '0;
    logic [31:0] per_slave_r_rdata_i = '0;
    logic        axi_slave_r_valid_o;
    logic        axi_slave_r_ready_i = 1'b0;
    logic [63:0] axi_slave_r_data_o;
    logic [1:0]  axi_slave_r_resp_o;
    logic        axi_slave_r_last_o;
    logic [2:0]  axi_slave_r_id_o;
    logic [5:0]  axi_slave_r_user_o;
    logic        axi_slave_b_valid_o;
    logic        axi_slave_b_ready_i = 1'b0;
    logic [1:0]  axi_slave_b_resp_o;
    logic [2:0]  axi_slave_b_id_o;
    logic [5:0]  axi_slave_b_user_o;

    axi2per_rsp_channel u_dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .trans_req_i         (trans_req_i),
        .trans_we_i          (trans_we_i),
        .trans_atop_r_i      (trans_atop_r_i),
        .trans_id_i          (trans_id_i),
        .trans_add_i         (trans_add_i),
        .trans_r_valid_o     (trans_r_valid_o),
        .per_slave_r_valid_i (per_slave_r_valid_i),
        .per_slave_r_opc_i   (per_slave_r_opc_i),
        .per_slave_r_id_i    (per_slave_r_id_i),
        .per_slave_r_rdata_i (per_slave_r_rdata_i),
        .axi_slave_r_valid_o (axi_slave_r_valid_o),
        .axi_slave_r_ready_i (axi_slave_r_ready_i),
        .axi_slave_r_data_o  (axi_slave_r_data_o),
        .axi_slave_r_resp_o  (axi_slave_r_resp_o),
        .axi_slave_r_last_o  (axi_slave_r_last_o),
        .axi_slave_r_id_o    (axi_slave_r_id_o),
        .axi_slave_r_user_o  (axi_slave_r_user_o),
        .axi_slave_b_valid_o (axi_slave_b_valid_o),
        .axi_slave_b_ready_i (axi_slave_b_ready_i),
        .axi_slave_b_resp_o  (axi_slave_b_resp_o),
        .axi_slave_b_id_o    (axi_slave_b_id_o),
        .axi_slave_b_user_o  (axi_slave_b_user_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        need_r;
        logic        need_b;
        logic [63:0] data;
        logic [1:0]  resp;
        logic [2:0]  id;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;
    logic rdy_rand = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Reference: what the AXI side must see for one peripheral transaction
    function automatic exp_t model(input logic we, input logic atop, input logic [31:0] addr,
                                   input logic [31:0] rdata, input logic opc, input logic [2:0] id);
        exp_t e;
        logic is_read;
        is_read  = we;
        e.need_r = is_read || atop;
        e.need_b = !is_read;
        e.data   = addr[2] ? {rdata, 32'h0} : {32'h0, rdata};
`ifdef AXI2PER_RSP_ERR_EN
        e.resp   = opc ? 2'b10 : 2'b00;
`else
        e.resp   = 2'b00;
        if (opc) e.resp = 2'b00;
`endif
        e.id     = id;
        return e;
    endfunction

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Random ready generation when enabled
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (rdy_rand) begin
                axi_slave_r_ready_i = 1'($urandom_range(0, 1));
                axi_slave_b_ready_i = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: compares every presented response against the scoreboard front
    exp_t m_e;
    logic m_r_done = 1'b0;
    logic m_b_done = 1'b0;
    logic m_hs_r, m_hs_b, m_exp_done;
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                m_r_done = 1'b0;
                m_b_done = 1'b0;
            end else if (exp_q.size() == 0) begin
                if (axi_slave_r_valid_o || axi_slave_b_valid_o || trans_r_valid_o)
                    check("spurious_output", 64'({axi_slave_r_valid_o, axi_slave_b_valid_o, trans_r_valid_o}), 64'd0);
            end else begin
                m_e    = exp_q[0];
                m_hs_r = axi_slave_r_valid_o && axi_slave_r_ready_i;
                m_hs_b = axi_slave_b_valid_o && axi_slave_b_ready_i;
                if (axi_slave_r_valid_o) begin
                    check("r_valid_expected", 64'(axi_slave_r_valid_o), 64'(m_e.need_r && !m_r_done));
                    check("r_data", axi_slave_r_data_o, m_e.data);
                    check("r_resp", 64'(axi_slave_r_resp_o), 64'(m_e.resp));
                    check("r_last", 64'(axi_slave_r_last_o), 64'd1);
                    check("r_id", 64'(axi_slave_r_id_o), 64'(m_e.id));
                    check("r_user", 64'(axi_slave_r_user_o), 64'd0);
                end
                if (axi_slave_b_valid_o) begin
                    check("b_valid_expected", 64'(axi_slave_b_valid_o), 64'(m_e.need_b && !m_b_done));
                    check("b_resp", 64'(axi_slave_b_resp_o), 64'(m_e.resp));
                    check("b_id", 64'(axi_slave_b_id_o), 64'(m_e.id));
                    check("b_user", 64'(axi_slave_b_user_o), 64'd0);
                end
                if (m_hs_r) m_r_done = 1'b1;
                if (m_hs_b) m_b_done = 1'b1;
                m_exp_done = (!m_e.need_r || m_r_done) && (!m_e.need_b || m_b_done);
                if (m_hs_r || m_hs_b || trans_r_valid_o)
                    check("completion_pulse", 64'(trans_r_valid_o), 64'(m_exp_done));
                if (trans_r_valid_o) done_cnt++;
                if (m_exp_done) begin
                    void'(exp_q.pop_front());
                    m_r_done = 1'b0;
                    m_b_done = 1'b0;
                end
            end
        end
    end

    task automatic send_req(input logic we, input logic atop, input logic [2:0] id,
                            input logic [31:0] addr, input logic [31:0] rdata, input logic opc);
        exp_q.push_back(model(we, atop, addr, rdata, opc, id));
        trans_req_i    = 1'b1;
        trans_we_i     = we;
        trans_atop_r_i = atop;
        trans_id_i     = id;
        trans_add_i    = addr;
        tick();
        trans_req_i    = 1'b0;
    endtask

    task automatic send_rsp(input logic [31:0] rdata, input logic opc, input int dly,
                            input logic need_r, input logic need_b);
        repeat (dly) tick();
        per_slave_r_valid_i = 1'b1;
        per_slave_r_rdata_i = rdata;
        per_slave_r_opc_i   = opc;
        per_slave_r_id_i    = 5'($urandom);
        tick();
        per_slave_r_valid_i = 1'b0;
        check("r_valid_latency", 64'(axi_slave_r_valid_o), 64'(need_r));
        check("b_valid_latency", 64'(axi_slave_b_valid_o), 64'(need_b));
    endtask

    task automatic issue(input logic we, input logic atop, input logic [2:0] id,
                         input logic [31:0] addr, input logic [31:0] rdata, input logic opc, input int dly);
        send_req(we, atop, id, addr, rdata, opc);
        send_rsp(rdata, opc, dly, we || atop, !we);
    endtask

    task automatic wait_done;
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 60) begin
            tick();
            n++;
        end
        check("retire_count", 64'(done_cnt - start), 64'd1);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {axi_slave_r_valid_o, axi_slave_b_valid_o, trans_r_valid_o,
                     axi_slave_r_id_o, axi_slave_b_id_o, axi_slave_r_resp_o, axi_slave_b_resp_o} , 64'd0);
        check({name, "_data"}, axi_slave_r_data_o, 64'd0);
    endtask

    task automatic do_reset;
        rst_i = 1'b1;
        exp_q.delete();
        tick();
        check_all_zero("reset_outputs");
        rst_i = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check_all_zero("initial_reset");
        rst_i = 1'b0;
        tick();

        // Read from the upper lane, R ready held high
        axi_slave_r_ready_i = 1'b1;
        axi_slave_b_ready_i = 1'b1;
        issue(1'b1, 1'b0, 3'd5, 32'h1000_0004, 32'hDEAD_BEEF, 1'b0, 0);
        wait_done();

        // Write with B back-pressured: valid and ID must hold
        axi_slave_b_ready_i = 1'b0;
        issue(1'b0, 1'b0, 3'd3, 32'h1000_0010, 32'h0, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            check("b_hold_valid", 64'(axi_slave_b_valid_o), 64'd1);
            check("b_hold_id", 64'(axi_slave_b_id_o), 64'd3);
            check("b_hold_no_retire", 64'(trans_r_valid_o), 64'd0);
            tick();
        end
        axi_slave_b_ready_i = 1'b1;
        wait_done();

        // Atomic load, R completes before B
        axi_slave_r_ready_i = 1'b1;
        axi_slave_b_ready_i = 1'b0;
        issue(1'b0, 1'b1, 3'd2, 32'h2000_0000, 32'h0000_0012, 1'b0, 0);
        tick();
        tick();
        axi_slave_b_ready_i = 1'b1;
        wait_done();

        // Atomic load, B completes before R
        axi_slave_r_ready_i = 1'b0;
        axi_slave_b_ready_i = 1'b1;
        issue(1'b0, 1'b1, 3'd6, 32'h2000_0000, 32'h0000_0012, 1'b0, 2);
        tick();
        tick();
        axi_slave_r_ready_i = 1'b1;
        wait_done();

        // Atomic load, both handshakes in the same cycle
        issue(1'b0, 1'b1, 3'd1, 32'h2000_0004, 32'hCAFE_0001, 1'b0, 0);
        wait_done();

        // Peripheral error on a write
        issue(1'b0, 1'b0, 3'd4, 32'h3000_0000, 32'h0, 1'b1, 0);
        wait_done();

        // Reset while waiting on the peripheral
        send_req(1'b1, 1'b0, 3'd7, 32'h4000_0000, 32'h5555_AAAA, 1'b0);
        do_reset();
        issue(1'b1, 1'b0, 3'd7, 32'h4000_0004, 32'h1234_5678, 1'b0, 0);
        wait_done();

        // Reset while responses are pending
        axi_slave_r_ready_i = 1'b0;
        axi_slave_b_ready_i = 1'b0;
        issue(1'b0, 1'b1, 3'd5, 32'h4000_0000, 32'h9999_0000, 1'b0, 0);
        tick();
        do_reset();
        axi_slave_r_ready_i = 1'b1;
        axi_slave_b_ready_i = 1'b1;
        issue(1'b1, 1'b0, 3'd2, 32'h4000_0000, 32'h0BAD_F00D, 1'b0, 1);
        wait_done();

        // Back-to-back random traffic with random ready back-pressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic we, atop;
            we   = 1'($urandom_range(0, 1));
            atop = !we && ($urandom_range(0, 2) == 0);
            issue(we, atop, 3'($urandom), $urandom, $urandom, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 2)));
            wait_done();
        end
        rdy_rand = 1'b0;

        tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
